// File: rtl/rs232_pkg.sv
// rs232_pkg: shared state encoding and frame constants for the RS-232 receive path
package rs232_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} rx_state_t;
  localparam int RS232_DATA_BITS = 8;
  localparam logic RS232_IDLE_LEVEL = 1'b1;
endpackage

// File: rtl/rs232_sync.sv
// rs232_sync: 2-flop synchronizer with configurable reset value
module rs232_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic m;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {q, m} <= {RST_VAL, RST_VAL};
    else {q, m} <= {m, d};
endmodule

// File: rtl/rs232_receiver.sv
// rs232_receiver: 8N1 oversampling UART receiver with a one-entry valid/ready holding register
import rs232_pkg::*;
module rs232_receiver #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       rx,
  input  logic                       rd_ready,
  output logic [RS232_DATA_BITS-1:0] data,
  output logic                       data_valid,
  output logic                       frame_err,
  output logic                       overrun,
  output logic                       idle
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0] LAST = 3'(RS232_DATA_BITS - 1);
  rx_state_t state;
  logic [CW-1:0] cnt;
  logic [2:0] bidx;
  logic [RS232_DATA_BITS-1:0] shreg;
  logic rx_s;
  rs232_sync #(.RST_VAL(RS232_IDLE_LEVEL)) u_sync (.clk(clk), .rst_n(rst_n), .d(rx), .q(rx_s));
  assign idle = state == IDLE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      bidx <= '0;
      shreg <= '0;
      data <= '0;
      data_valid <= 1'b0;
      frame_err <= 1'b0;
      overrun <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      overrun <= 1'b0;
      if (data_valid && rd_ready) data_valid <= 1'b0;
      case (state)
        IDLE: if (!rx_s) begin
          state <= START;
          cnt <= '0;
        end
        START: if (cnt == HALF) begin
          state <= rx_s ? IDLE : DATA;
          cnt <= '0;
          bidx <= '0;
        end else cnt <= cnt + CW'(1);
        DATA: if (cnt == FULL) begin
          shreg <= {rx_s, shreg[RS232_DATA_BITS-1:1]};
          cnt <= '0;
          bidx <= bidx + 3'd1;
          if (bidx == LAST) state <= STOP;
        end else cnt <= cnt + CW'(1);
        STOP: if (cnt == FULL) begin
          state <= rx_s ? IDLE : BREAK;
          cnt <= '0;
          // a late consume in this same cycle frees the slot for the new byte
          if (!rx_s) frame_err <= 1'b1;
          else if (data_valid && !rd_ready) overrun <= 1'b1;
          else begin
            data <= shreg;
            data_valid <= 1'b1;
          end
        end else cnt <= cnt + CW'(1);
        BREAK: if (rx_s) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_rs232_receiver.sv
// tb_rs232_receiver: directed table-driven bench for rs232_receiver at 16 clocks per bit
`timescale 1ns/1ps
module tb_rs232_receiver;
  logic clk = 1'b0, rst_n = 1'b0, rx = 1'b1, rd_ready = 1'b1;
  logic [7:0] data;
  logic data_valid, frame_err, overrun, idle;
  int nvec = 0, nerr = 0, cyc = 0, t0 = 0;
  int dv_rise, dv_hi, dv_cyc, ferr_n, ferr_cyc, ovr_n, both_n = 0;
  logic dv_q = 1'b0, mon_clr = 1'b0;

  rs232_receiver #(.CLKS_PER_BIT(16)) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx), .rd_ready(rd_ready), .data(data),
    .data_valid(data_valid), .frame_err(frame_err), .overrun(overrun), .idle(idle)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mon_clr) begin
      dv_rise = 0; dv_hi = 0; dv_cyc = -1; ferr_n = 0; ferr_cyc = -1; ovr_n = 0;
    end else begin
      if (data_valid && !dv_q) begin dv_rise++; dv_cyc = cyc; end
      if (data_valid) dv_hi++;
      if (frame_err) begin ferr_n++; ferr_cyc = cyc; end
      if (overrun) ovr_n++;
      if (frame_err && overrun) both_n++;
    end
    dv_q = data_valid;
  end

  task automatic chk(input string name, input int act, input int exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clr();
    mon_clr = 1'b1;
    cycles(1);
    mon_clr = 1'b0;
  endtask

  // drives one 160-cycle frame; optional rd_ready pulse in the stop-sample cycle
  task automatic send(input logic [7:0] b, input logic stop, input logic pulse);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int n = 0; n < 160; n++) begin
      @(posedge clk); #1;
      if (n == 0) t0 = cyc;
      rx = f[n/16];
      if (pulse && n == 154) rd_ready = 1'b1;
      if (pulse && n == 155) rd_ready = 1'b0;
    end
  endtask

  typedef struct {
    logic [7:0] d;
    logic       stop;
    logic [7:0] exp_data;
    int         exp_dv;
    int         exp_ferr;
  } vec_t;
  vec_t tbl[5];

  initial begin
    logic [9:0] f;
    tbl[0] = '{8'hA5, 1'b1, 8'hA5, 1, 0};
    tbl[1] = '{8'h00, 1'b1, 8'h00, 1, 0};
    tbl[2] = '{8'hFF, 1'b1, 8'hFF, 1, 0};
    tbl[3] = '{8'h3C, 1'b0, 8'hFF, 0, 1};
    tbl[4] = '{8'h81, 1'b1, 8'h81, 1, 0};

    cycles(3);
    chk("reset idle", idle, 1);
    chk("reset data_valid", data_valid, 0);
    chk("reset data", data, 0);
    chk("reset frame_err", frame_err, 0);
    chk("reset overrun", overrun, 0);
    rst_n = 1'b1;
    cycles(4);

    foreach (tbl[i]) begin
      clr();
      send(tbl[i].d, tbl[i].stop, 1'b0);
      rx = 1'b1;
      cycles(6);
      chk($sformatf("vec%0d data", i), data, tbl[i].exp_data);
      chk($sformatf("vec%0d dv pulses", i), dv_rise, tbl[i].exp_dv);
      chk($sformatf("vec%0d dv width", i), dv_hi, tbl[i].exp_dv);
      chk($sformatf("vec%0d frame_err", i), ferr_n, tbl[i].exp_ferr);
      chk($sformatf("vec%0d overrun", i), ovr_n, 0);
      chk($sformatf("vec%0d idle", i), idle, 1);
      if (tbl[i].exp_dv != 0) chk($sformatf("vec%0d dv latency", i), dv_cyc - t0, 155);
      else chk($sformatf("vec%0d ferr latency", i), ferr_cyc - t0, 155);
    end

    clr();
    rx = 1'b0;
    cycles(5);
    rx = 1'b1;
    cycles(3);
    chk("glitch idle low", idle, 0);
    cycles(20);
    chk("glitch idle back", idle, 1);
    chk("glitch dv", dv_rise, 0);
    chk("glitch frame_err", ferr_n, 0);

    clr();
    send(8'h3C, 1'b0, 1'b0);
    cycles(40);
    chk("break idle low", idle, 0);
    chk("break ferr single", ferr_n, 1);
    chk("break dv", dv_rise, 0);
    rx = 1'b1;
    cycles(2);
    chk("break idle before rx_s", idle, 0);
    cycles(2);
    chk("break idle after rx_s", idle, 1);
    send(8'h55, 1'b1, 1'b0);
    cycles(4);
    chk("after break data", data, 8'h55);
    chk("after break dv", dv_rise, 1);
    chk("after break ferr", ferr_n, 1);

    rd_ready = 1'b0;
    clr();
    send(8'h11, 1'b1, 1'b0);
    cycles(4);
    chk("ovr first dv", data_valid, 1);
    chk("ovr first data", data, 8'h11);
    send(8'h22, 1'b1, 1'b0);
    cycles(4);
    chk("ovr held data", data, 8'h11);
    chk("ovr held dv", data_valid, 1);
    chk("ovr pulses", ovr_n, 1);
    rd_ready = 1'b1;
    cycles(1);
    rd_ready = 1'b0;
    chk("ovr consume", data_valid, 0);

    clr();
    send(8'h11, 1'b1, 1'b0);
    cycles(4);
    send(8'h22, 1'b1, 1'b1);
    cycles(4);
    chk("simul data", data, 8'h22);
    chk("simul dv", data_valid, 1);
    chk("simul overrun", ovr_n, 0);

    f = {1'b1, 8'hF0, 1'b0};
    for (int n = 0; n < 88; n++) begin
      @(posedge clk); #1;
      rx = f[n/16];
    end
    #2 rst_n = 1'b0;
    #1;
    chk("midrst dv", data_valid, 0);
    chk("midrst data", data, 0);
    chk("midrst idle", idle, 1);
    chk("midrst frame_err", frame_err, 0);
    chk("midrst overrun", overrun, 0);
    rx = 1'b1;
    cycles(3);
    rst_n = 1'b1;
    rd_ready = 1'b1;
    cycles(20);
    clr();
    send(8'hF0, 1'b1, 1'b0);
    cycles(4);
    chk("post rst data", data, 8'hF0);
    chk("post rst dv", dv_rise, 1);
    chk("post rst ferr", ferr_n, 0);
    chk("ferr/overrun exclusive", both_n, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
